// File: rtl/jacobi_ctrl.sv
// ============================================================================
//  Module   : jacobi_ctrl
//  Purpose  : Pivot-search / rotation-issue controller for a Jacobi
//             eigen-solver; holds the matrix, scans for the largest
//             off-diagonal element and hands it to a rotation engine.
//             Optional JACOBI_ABS_PIVOT_EN selects magnitude-based pivoting.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jacobi_ctrl #(
    parameter int WIDTH    = 16,
    parameter int N_STOCKS = 4,
    parameter int MAX_ITER = 32,
    localparam int IW      = $clog2(N_STOCKS),
    localparam int CW      = $clog2(MAX_ITER + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] thresh_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             rot_valid,
    input  logic             rot_ready,
    output logic [IW-1:0]    pivot_i,
    output logic [IW-1:0]    pivot_j,
    output logic [WIDTH-1:0] pivot_val,
    input  logic             wb_valid,
    input  logic [IW-1:0]    wb_i,
    input  logic [IW-1:0]    wb_j,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             rot_done,
    input  logic [IW-1:0]    rd_i,
    input  logic [IW-1:0]    rd_j,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic [CW-1:0]    iter_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic signed [WIDTH-1:0] C_MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] C_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [IW-1:0]           C_LAST     = IW'(N_STOCKS - 1);
    localparam logic [CW-1:0]           C_MAX_ITER = CW'(MAX_ITER);

    state_t                   r_state;
    logic signed [WIDTH-1:0]  r_mat [N_STOCKS][N_STOCKS];
    logic [IW-1:0]            r_row;
    logic [IW-1:0]            r_col;
    logic signed [WIDTH-1:0]  r_best;
    logic [IW-1:0]            r_best_i;
    logic [IW-1:0]            r_best_j;
    logic signed [WIDTH-1:0]  r_thresh;

    logic signed [WIDTH-1:0]  w_raw;
    logic signed [WIDTH-1:0]  w_mag;
    logic                     w_take;
    logic                     w_last;
    logic signed [WIDTH-1:0]  w_fin_best;
    logic [IW-1:0]            w_fin_i;
    logic [IW-1:0]            w_fin_j;
    logic                     w_wb_in_range;

    assign w_raw = r_mat[r_row][r_col];

`ifdef JACOBI_ABS_PIVOT_EN
    // The most-negative value has no positive twin, so it saturates.
    always_comb begin
        if (w_raw == C_MIN) begin
            w_mag = C_MAX;
        end else if (w_raw < 0) begin
            w_mag = -w_raw;
        end else begin
            w_mag = w_raw;
        end
    end
`else
    assign w_mag = w_raw;
`endif

    // Strictly-greater keeps the earliest element on ties.
    assign w_take     = (r_row != r_col) && (w_mag > r_best);
    assign w_last     = (r_row == C_LAST) && (r_col == C_LAST);
    assign w_fin_best = w_take ? w_mag : r_best;
    assign w_fin_i    = w_take ? r_row : r_best_i;
    assign w_fin_j    = w_take ? r_col : r_best_j;

    assign w_wb_in_range = (int'(wb_i) < N_STOCKS) && (int'(wb_j) < N_STOCKS);
    assign rd_data = ((int'(rd_i) < N_STOCKS) && (int'(rd_j) < N_STOCKS))
                   ? r_mat[rd_i][rd_j] : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            for (int r = 0; r < N_STOCKS; r++) begin
                for (int c = 0; c < N_STOCKS; c++) begin
                    r_mat[r][c] <= '0;
                end
            end
            r_row      <= '0;
            r_col      <= '0;
            r_best     <= C_MIN;
            r_best_i   <= '0;
            r_best_j   <= '0;
            r_thresh   <= '0;
            pivot_i    <= '0;
            pivot_j    <= '0;
            pivot_val  <= '0;
            iter_count <= '0;
            rot_valid  <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        r_state    <= S_LOAD;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        r_thresh   <= thresh_in;
                        r_row      <= '0;
                        r_col      <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_mat[r_row][r_col] <= in_data;
                        if (w_last) begin
                            r_state  <= S_SCAN;
                            in_ready <= 1'b0;
                            r_row    <= '0;
                            r_col    <= '0;
                            r_best   <= C_MIN;
                        end else if (r_col == C_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    r_best   <= w_fin_best;
                    r_best_i <= w_fin_i;
                    r_best_j <= w_fin_j;
                    if (w_last) begin
                        if (w_fin_best <= r_thresh) begin
                            r_state   <= S_DONE;
                            converged <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (iter_count == C_MAX_ITER) begin
                            r_state   <= S_DONE;
                            converged <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            pivot_i   <= w_fin_i;
                            pivot_j   <= w_fin_j;
                            pivot_val <= w_fin_best;
                            rot_valid <= 1'b1;
                        end
                    end else if (r_col == C_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (rot_ready) begin
                        r_state    <= S_WAIT;
                        rot_valid  <= 1'b0;
                        iter_count <= iter_count + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A write-back coincident with rot_done lands before the rescan.
                    if (wb_valid && w_wb_in_range) begin
                        r_mat[wb_i][wb_j] <= wb_data;
                    end
                    if (rot_done) begin
                        r_state <= S_SCAN;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_best  <= C_MIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jacobi_ctrl.sv
// ============================================================================
//  Module   : tb_jacobi_ctrl
//  Purpose  : Self-checking bench for jacobi_ctrl against a plain-arithmetic
//             pivot-search model; honours JACOBI_ABS_PIVOT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jacobi_ctrl;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int MAXIT = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [15:0] thresh_in;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        rot_valid;
    logic        rot_ready;
    logic [1:0]  pivot_i;
    logic [1:0]  pivot_j;
    logic [15:0] pivot_val;
    logic        wb_valid;
    logic [1:0]  wb_i;
    logic [1:0]  wb_j;
    logic [15:0] wb_data;
    logic        rot_done;
    logic [1:0]  rd_i;
    logic [1:0]  rd_j;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        converged;
    logic [1:0]  iter_count;

    jacobi_ctrl #(.WIDTH(WIDTH), .N_STOCKS(N), .MAX_ITER(MAXIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .thresh_in(thresh_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rot_valid(rot_valid), .rot_ready(rot_ready),
        .pivot_i(pivot_i), .pivot_j(pivot_j), .pivot_val(pivot_val),
        .wb_valid(wb_valid), .wb_i(wb_i), .wb_j(wb_j), .wb_data(wb_data),
        .rot_done(rot_done), .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data),
        .busy(busy), .done(done), .converged(converged), .iter_count(iter_count)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    int mm [N][N];
    int m_iter;
    int m_thresh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int mag(input int v);
`ifdef JACOBI_ABS_PIVOT_EN
        int a;
        a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
`else
        return v;
`endif
    endfunction

    // Largest off-diagonal value, first in row-major order on ties.
    task automatic model_scan(output int bi, output int bj, output int bv);
        bi = 0; bj = 0; bv = -32768;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (r != c && mag(mm[r][c]) > bv) begin
                    bv = mag(mm[r][c]); bi = r; bj = c;
                end
            end
        end
    endtask

    task automatic clear_mm();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mm[r][c] = 0;
    endtask

    task automatic do_start(input int thr);
        @(negedge clk_in);
        start_in  = 1'b1;
        thresh_in = 16'(thr);
        m_thresh  = thr;
        m_iter    = 0;
        @(negedge clk_in);
        start_in  = 1'b0;
        chk("in_ready_after_start", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic do_load(input bit gaps);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (gaps && ($urandom % 3 == 0)) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    @(negedge clk_in);
                end
                in_valid = 1'b1;
                in_data  = 16'(mm[r][c]);
                @(negedge clk_in);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_matrix();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                rd_i = 2'(r); rd_j = 2'(c);
                #1;
                chk("rd_data", 32'($signed(rd_data)), 32'(mm[r][c]));
            end
        end
    endtask

    // mode 0: engine writes 9 to the pivot; 1: random values; 2: writes 0.
    task automatic run_engine(input int mode);
        int  bi, bj, bv, waited, hold, nw, ti, tj, val;
        bit  fin, exp_done;
        fin = 1'b0;
        while (!fin) begin
            waited = 0;
            while (!(done || rot_valid) && waited < 200) begin
                @(negedge clk_in);
                waited++;
            end
            chk("event_timeout", {31'b0, done | rot_valid}, 32'd1);
            if (waited >= 200) return;
            model_scan(bi, bj, bv);
            exp_done = (bv <= m_thresh) || (m_iter == MAXIT);
            chk("done_vs_model", {31'b0, done}, {31'b0, exp_done});
            if (done) begin
                chk("converged", {31'b0, converged}, {31'b0, bv <= m_thresh});
                chk("iter_count_final", 32'(iter_count), 32'(m_iter));
                chk("busy_in_done", {31'b0, busy}, 32'd0);
                fin = 1'b1;
            end else if (exp_done) begin
                fin = 1'b1;
            end else begin
                chk("pivot_i", 32'(pivot_i), 32'(bi));
                chk("pivot_j", 32'(pivot_j), 32'(bj));
                chk("pivot_val", 32'($signed(pivot_val)), 32'(bv));
                chk("iter_before_accept", 32'(iter_count), 32'(m_iter));
                // Stray write-backs and rot_done while the command waits must be ignored.
                hold = $urandom_range(0, 2);
                for (int h = 0; h < hold; h++) begin
                    wb_valid = 1'b1; wb_i = 2'(bi); wb_j = 2'(bj); wb_data = 16'h7777;
                    rot_done = (h == 0);
                    @(negedge clk_in);
                    chk("rot_valid_hold", {31'b0, rot_valid}, 32'd1);
                    chk("pivot_val_hold", 32'($signed(pivot_val)), 32'(bv));
                end
                wb_valid = 1'b0; rot_done = 1'b0; rot_ready = 1'b1;
                @(negedge clk_in);
                rot_ready = 1'b0;
                m_iter++;
                chk("rot_valid_after_accept", {31'b0, rot_valid}, 32'd0);
                chk("iter_after_accept", 32'(iter_count), 32'(m_iter));
                nw = $urandom_range(1, 2);
                for (int w = 0; w < nw; w++) begin
                    if ($urandom % 2 == 0) @(negedge clk_in);
                    ti = bi; tj = bj;
                    if (w > 0 && mode == 1) begin
                        ti = $urandom_range(0, N-1); tj = $urandom_range(0, N-1);
                    end
                    val = (mode == 0) ? 9 : (mode == 2) ? 0 : int'($urandom_range(0, 200)) - 100;
                    wb_valid = 1'b1; wb_i = 2'(ti); wb_j = 2'(tj); wb_data = 16'(val);
                    rot_done = (w == nw - 1);
                    mm[ti][tj] = val;
                    @(negedge clk_in);
                    wb_valid = 1'b0; rot_done = 1'b0;
                end
                // First SCAN cycle: this write-back must be dropped.
                wb_valid = 1'b1; wb_i = 2'd0; wb_j = 2'd1; wb_data = 16'h5a5a;
                @(negedge clk_in);
                wb_valid = 1'b0;
            end
        end
        check_matrix();
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rot_valid"}, {31'b0, rot_valid}, 32'd0);
        chk({pfx, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({pfx, "_busy"}, {31'b0, busy}, 32'd0);
        chk({pfx, "_done"}, {31'b0, done}, 32'd0);
        chk({pfx, "_converged"}, {31'b0, converged}, 32'd0);
        chk({pfx, "_iter"}, 32'(iter_count), 32'd0);
        chk({pfx, "_pivot_i"}, 32'(pivot_i), 32'd0);
        chk({pfx, "_pivot_j"}, 32'(pivot_j), 32'd0);
        chk({pfx, "_pivot_val"}, 32'(pivot_val), 32'd0);
        clear_mm();
        check_matrix();
    endtask

    initial begin
        int  thr, waited;
        bit  any_rv;
        rst_in = 1'b1; start_in = 1'b0; thresh_in = '0; in_valid = 1'b0; in_data = '0;
        rot_ready = 1'b0; wb_valid = 1'b0; wb_i = '0; wb_j = '0; wb_data = '0;
        rot_done = 1'b0; rd_i = '0; rd_j = '0;
        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        rst_in = 1'b0;

        // All-zero matrix: converges after 16 load + 16 scan cycles.
        clear_mm();
        do_start(0);
        do_load(1'b0);
        repeat (15) @(negedge clk_in);
        chk("zero_done_early", {31'b0, done}, 32'd0);
        @(negedge clk_in);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_converged", {31'b0, converged}, 32'd1);
        chk("zero_iter", 32'(iter_count), 32'd0);

        // Identity with 5 at [1][2]; engine writes 9 back, runs to the iteration limit.
        clear_mm();
        for (int k = 0; k < N; k++) mm[k][k] = 1;
        mm[1][2] = 5;
        do_start(0);
        do_load(1'b0);
        run_engine(0);

        // Tie between [0][1] and [2][3].
        clear_mm();
        mm[0][1] = 7; mm[2][3] = 7;
        do_start(0);
        do_load(1'b1);
        run_engine(2);

        // Lone negative entry, and the most-negative value.
        clear_mm();
        mm[3][0] = -20;
        do_start(0);
        do_load(1'b0);
        run_engine(2);
        clear_mm();
        mm[2][1] = -32768; mm[0][3] = -5;
        do_start(0);
        do_load(1'b1);
        run_engine(2);

        // Randomized matrices and thresholds.
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mm[r][c] = int'($urandom_range(0, 200)) - 100;
            thr = int'($urandom_range(0, 150)) - 50;
            do_start(thr);
            do_load(1'b1);
            run_engine(1);
        end

        // Reset while waiting for the rotation.
        clear_mm();
        mm[1][2] = 5;
        do_start(0);
        do_load(1'b0);
        waited = 0;
        while (!rot_valid && waited < 100) begin
            @(negedge clk_in);
            waited++;
        end
        chk("reset_test_rot_valid", {31'b0, rot_valid}, 32'd1);
        rot_ready = 1'b1;
        @(negedge clk_in);
        rot_ready = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        rot_ready = 1'b1; rot_done = 1'b1;
        any_rv = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            any_rv = any_rv | rot_valid | busy;
        end
        rot_ready = 1'b0; rot_done = 1'b0;
        chk("no_reissue_after_reset", {31'b0, any_rv}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
